// File: rtl/flexbus_initiator.sv
`default_nettype none
// ---------------------------------------------------------------------------
// flexbus_initiator : single-beat command to multiplexed-AD FlexBus cycle master
// rev 1.0 : initial release
// ---------------------------------------------------------------------------
module flexbus_initiator #(
  parameter int AD_WIDTH    = 32,
  parameter int WAIT_STATES = 0,
  parameter int TURN_CYCLES = 1
) (
  input  logic                CLK,
  input  logic                RST,
  input  logic                cmd_valid,
  output logic                cmd_ready,
  input  logic                cmd_rw,
  input  logic [AD_WIDTH-1:0] cmd_addr,
  input  logic [AD_WIDTH-1:0] cmd_wdata,
  output logic                rsp_valid,
  output logic                rsp_rw,
  output logic [AD_WIDTH-1:0] rsp_rdata,
  output logic                busy,
  output logic                FB_ALE,
  output logic                FB_CS,
  output logic                FB_RW,
  output logic [AD_WIDTH-1:0] FB_AD_o,
  output logic                FB_AD_oe,
  input  logic [AD_WIDTH-1:0] FB_AD_i
);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_ADDR = 2'd1,
    S_DATA = 2'd2,
    S_TURN = 2'd3
  } state_t;

  // Counter reload values; anything past the 4-bit range simply saturates.
  localparam logic [3:0] WAIT_LOAD = (WAIT_STATES > 15) ? 4'd15 :
                                     (WAIT_STATES < 0)  ? 4'd0  : 4'(WAIT_STATES);
  localparam logic [3:0] TURN_LOAD = (TURN_CYCLES > 16) ? 4'd15 :
                                     (TURN_CYCLES < 1)  ? 4'd0  : 4'(TURN_CYCLES - 1);

  state_t              state;
  logic [3:0]          cnt;
  logic                rw_q;
  logic [AD_WIDTH-1:0] wdata_q;

  assign cmd_ready = (state == S_IDLE);

  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      state     <= S_IDLE;
      cnt       <= 4'd0;
      rw_q      <= 1'b1;
      wdata_q   <= '0;
      rsp_valid <= 1'b0;
      rsp_rw    <= 1'b0;
      rsp_rdata <= '0;
      busy      <= 1'b0;
      FB_ALE    <= 1'b0;
      FB_CS     <= 1'b1;
      FB_RW     <= 1'b1;
      FB_AD_o   <= '0;
      FB_AD_oe  <= 1'b0;
    end else begin
      case (state)
        S_IDLE: begin
          rsp_valid <= 1'b0;
          if (cmd_valid) begin
            state    <= S_ADDR;
            busy     <= 1'b1;
            rw_q     <= cmd_rw;
            wdata_q  <= cmd_wdata;
            FB_ALE   <= 1'b1;
            FB_CS    <= 1'b1;
            FB_RW    <= cmd_rw;
            FB_AD_o  <= cmd_addr;
            FB_AD_oe <= 1'b1;
          end
        end
        S_ADDR: begin
          // Reads release AD on this very edge so the target can drive it in DATA.
          state    <= S_DATA;
          cnt      <= WAIT_LOAD;
          FB_ALE   <= 1'b0;
          FB_CS    <= 1'b0;
          FB_AD_o  <= rw_q ? '0 : wdata_q;
          FB_AD_oe <= ~rw_q;
        end
        S_DATA: begin
          if (cnt == 4'd0) begin
            state     <= S_TURN;
            cnt       <= TURN_LOAD;
            FB_CS     <= 1'b1;
            FB_RW     <= 1'b1;
            FB_AD_o   <= '0;
            FB_AD_oe  <= 1'b0;
            rsp_valid <= 1'b1;
            rsp_rw    <= rw_q;
            rsp_rdata <= rw_q ? FB_AD_i : '0;
          end else begin
            cnt <= cnt - 4'd1;
          end
        end
        S_TURN: begin
          rsp_valid <= 1'b0;
          if (cnt == 4'd0) begin
            state <= S_IDLE;
            busy  <= 1'b0;
          end else begin
            cnt <= cnt - 4'd1;
          end
        end
        default: state <= S_IDLE;
      endcase
    end
  end

endmodule
`default_nettype wire
